rom_sdram_writer: RTL and testbench
===================================

ROM_SDRAM_WRITER -- requirements
Module: rom_sdram_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 23'h000000: SDRAM byte address of ROM byte 0; bit 0 SHALL be 0.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: word FIFO entries; power of two, at least 2.
REQ-003 SHALL have port wclk  in  1: the single clock.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port rom_loading  in  1: level; high while a ROM stream is in progress.
REQ-006 SHALL have port rom_do  in  8: stream byte.
REQ-007 SHALL have port rom_do_valid  in  1: one-cycle strobe qualifying rom_do.
REQ-008 SHALL have port rom_mask  in  24: ROM size mask, stable while rom_loading is high.
REQ-009 SHALL have port mem_req  out  1: SDRAM write request.
REQ-010 SHALL have port mem_ack  in  1: one-cycle acceptance of mem_req.
REQ-011 SHALL have port mem_addr  out  23: SDRAM byte address, bit 0 always 0.
REQ-012 SHALL have port mem_din  out  16: write data, earlier byte in [7:0].
REQ-013 SHALL have port mem_ds  out  2: byte enables, [0] for the low byte.
REQ-014 SHALL have port load_done  out  1: one-cycle pulse when all data of a load has been written.
REQ-015 SHALL have port byte_cnt  out  24: bytes accepted in the current or last load.
REQ-016 SHALL have port overflow  out  1: sticky flag; a word was dropped because the FIFO was full.
REQ-017 SHALL have port checksum  out  16: sum of accepted bytes (see Configuration).

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, FLUSH and DONE.
REQ-019 In IDLE with rom_loading=1, the FSM SHALL move to LOAD next cycle and clear byte_cnt, checksum, overflow, the FIFO and the pack register on that entry.
REQ-020 In LOAD, each rom_do_valid SHALL accept one byte and increment byte_cnt (24-bit wrap).
REQ-021 An even-numbered byte SHALL go to the pack low half; an odd-numbered byte SHALL complete the word and push {word, ds=2'b11} to the FIFO in the same cycle.
REQ-022 rom_do_valid outside LOAD, or in the cycle where rom_loading is already 0, SHALL be ignored.
REQ-023 In LOAD with rom_loading=0 and an odd byte pending, the block SHALL push {8'h00, byte} with ds=2'b01, then go to FLUSH; with no byte pending it SHALL go straight to FLUSH.
REQ-024 A push to a full FIFO with no pop in the same cycle SHALL drop the word and set overflow; a push and pop in the same cycle on a full FIFO SHALL succeed.
REQ-025 The write side SHALL pop the FIFO only when mem_req is low, and assert mem_req on the next cycle.
REQ-026 mem_addr, mem_din and mem_ds SHALL stay stable while mem_req is high.
REQ-027 mem_req SHALL drop in the cycle after mem_ack, and the next request SHALL come no earlier than the cycle after that drop.
REQ-028 mem_ack while mem_req is low SHALL be ignored.
REQ-029 The write address for word index w SHALL be BASE_ADDR + ((2*w) & rom_mask[22:0] & 23'h7FFFFE), so words past the mask wrap and mirror.
REQ-030 FLUSH SHALL go to DONE when the FIFO is empty and mem_req is low.
REQ-031 DONE SHALL pulse load_done for exactly one cycle and then go to IDLE.
REQ-032 If rom_loading is high again on return to IDLE, a new load SHALL start per REQ-019.
REQ-033 Load-to-write latency: the completing odd byte at cycle t SHALL give mem_req high at t+2 when the FIFO is empty and the write side is idle.

Reset
REQ-034 Reset SHALL set: state IDLE, mem_req 0, mem_addr 0, mem_din 0, mem_ds 2'b00, load_done 0, byte_cnt 0, overflow 0, checksum 0, FIFO empty, pack register empty.
REQ-035 Reset asserted mid-request SHALL drop mem_req in the next cycle and abandon the load with no load_done.

Configuration
REQ-036 With macro ROM_SDRAM_WRITER_CHECKSUM_EN defined, checksum SHALL add each accepted byte, zero-extended, modulo 2^16 in the acceptance cycle.
REQ-037 Without ROM_SDRAM_WRITER_CHECKSUM_EN, checksum SHALL be constant 16'h0000; the port list SHALL be identical in both builds.

Structure
REQ-038 Package rom_sdram_writer_pkg SHALL hold the state enum, the DS_FULL=2'b11 and DS_LOW=2'b01 constants, and the FIFO entry type (18 bits: data plus ds).
REQ-039 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and depth, providing full and empty flags.

Verification
REQ-040 Bytes 01,02,03,04 on consecutive cycles, mem_ack one cycle after each req -> writes (0x000000, 16'h0201, 11), (0x000002, 16'h0403, 11); load_done once; byte_cnt=4; checksum=0x000A when the macro is defined.
REQ-041 Three bytes AA,BB,CC, then rom_loading=0 -> last write (0x000002, 16'h00CC, ds=01); byte_cnt=3.
REQ-042 rom_mask=24'h000003, 8 bytes -> word addresses 0,2,0,2 in order; no overflow.
REQ-043 FIFO_DEPTH=2, mem_ack held low for 20 cycles, 10 bytes streamed -> overflow=1; exactly 3 words written after mem_ack resumes.
REQ-044 Reset asserted while mem_req=1 -> mem_req=0 next cycle; no load_done; all outputs at REQ-034 values.
REQ-045 rom_loading held high through DONE -> second load starts; byte_cnt restarts at 0.

Source files
------------

// File: rtl/rom_sdram_writer_pkg.sv
// Shared types and constants for the ROM-to-SDRAM writer: FSM states,
// byte-enable codes, the FIFO entry layout and the word address helper.
package rom_sdram_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_FLUSH = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] DS_FULL = 2'b11;
    localparam logic [1:0] DS_LOW  = 2'b01;

    localparam int ENTRY_W = 18;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  ds;
    } fifo_entry_t;

    // Word index to byte address; the mask keeps oversized streams mirroring.
    function automatic logic [22:0] word_addr(
        input logic [22:0] base,
        input logic [21:0] widx,
        input logic [22:0] mask
    );
        return base + ({widx, 1'b0} & mask & 23'h7FFFFE);
    endfunction

endpackage

// File: rtl/rom_sdram_writer_sync_fifo.sv
// Single-clock FIFO with full/empty flags; a push into a full FIFO is only
// taken when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic             wclk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against the flags.
    always_comb begin
        full      = (count_r == DEPTH_C);
        empty     = (count_r == '0);
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        dout      = mem_r[rd_ptr_r];
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge wclk) begin
        if (reset || clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge wclk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/rom_sdram_writer.sv
// Packs a ROM byte stream into 16-bit SDRAM writes through a word FIFO.
// Optional running byte checksum: define ROM_SDRAM_WRITER_CHECKSUM_EN.
module rom_sdram_writer
    import rom_sdram_writer_pkg::*;
#(
    parameter logic [22:0] BASE_ADDR  = 23'h000000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wclk,
    input  logic        reset,
    input  logic        rom_loading,
    input  logic [7:0]  rom_do,
    input  logic        rom_do_valid,
    input  logic [23:0] rom_mask,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_ds,
    output logic        load_done,
    output logic [23:0] byte_cnt,
    output logic        overflow,
    output logic [15:0] checksum
);

    state_t      state_r;
    logic [7:0]  pack_r;
    logic        pack_valid_r;
    logic [23:0] byte_cnt_r;
    logic        overflow_r;
    logic        load_done_r;
    logic [21:0] word_idx_r;
    logic        mem_req_r;
    logic [22:0] mem_addr_r;
    logic [15:0] mem_din_r;
    logic [1:0]  mem_ds_r;

    logic        start_s;
    logic        accept_s;
    logic        push_s;
    fifo_entry_t push_entry_s;
    logic        pop_s;
    logic        drop_s;
    fifo_entry_t fifo_dout_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        unused_mask_s;

    assign unused_mask_s = rom_mask[23];

    // Stream acceptance, word completion and write-side pop decisions.
    always_comb begin
        start_s      = (state_r == ST_IDLE) && rom_loading;
        accept_s     = (state_r == ST_LOAD) && rom_loading && rom_do_valid;
        push_s       = 1'b0;
        push_entry_s = '0;
        if (accept_s && pack_valid_r) begin
            push_s            = 1'b1;
            push_entry_s.data = {rom_do, pack_r};
            push_entry_s.ds   = DS_FULL;
        end else if ((state_r == ST_LOAD) && !rom_loading && pack_valid_r) begin
            push_s            = 1'b1;
            push_entry_s.data = {8'h00, pack_r};
            push_entry_s.ds   = DS_LOW;
        end else begin
            push_s       = 1'b0;
            push_entry_s = '0;
        end
        pop_s  = !mem_req_r && !fifo_empty_s;
        drop_s = push_s && fifo_full_s && !pop_s;
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .wclk  (wclk),
        .reset (reset),
        .clr   (start_s),
        .push  (push_s),
        .din   (push_entry_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Load sequencing: byte packing, counters, overflow and completion pulse.
    always_ff @(posedge wclk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            pack_r       <= 8'h00;
            pack_valid_r <= 1'b0;
            byte_cnt_r   <= 24'h000000;
            overflow_r   <= 1'b0;
            load_done_r  <= 1'b0;
        end else begin
            load_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rom_loading) begin
                        state_r      <= ST_LOAD;
                        pack_r       <= 8'h00;
                        pack_valid_r <= 1'b0;
                        byte_cnt_r   <= 24'h000000;
                        overflow_r   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!rom_loading) begin
                        pack_valid_r <= 1'b0;
                        state_r      <= ST_FLUSH;
                    end else if (rom_do_valid) begin
                        byte_cnt_r <= byte_cnt_r + 24'd1;
                        if (pack_valid_r) begin
                            pack_valid_r <= 1'b0;
                        end else begin
                            pack_r       <= rom_do;
                            pack_valid_r <= 1'b1;
                        end
                    end
                    if (drop_s) begin
                        overflow_r <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty_s && !mem_req_r) begin
                        state_r     <= ST_DONE;
                        load_done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Write side: one request in flight, fields frozen until acknowledged.
    always_ff @(posedge wclk) begin
        if (reset) begin
            mem_req_r  <= 1'b0;
            mem_addr_r <= 23'h000000;
            mem_din_r  <= 16'h0000;
            mem_ds_r   <= 2'b00;
            word_idx_r <= 22'h000000;
        end else begin
            if (mem_req_r) begin
                if (mem_ack) begin
                    mem_req_r <= 1'b0;
                end
            end else if (pop_s) begin
                mem_req_r  <= 1'b1;
                mem_addr_r <= word_addr(BASE_ADDR, word_idx_r, rom_mask[22:0]);
                mem_din_r  <= fifo_dout_s.data;
                mem_ds_r   <= fifo_dout_s.ds;
            end
            if (start_s) begin
                word_idx_r <= 22'h000000;
            end else if (pop_s) begin
                word_idx_r <= word_idx_r + 22'd1;
            end
        end
    end

`ifdef ROM_SDRAM_WRITER_CHECKSUM_EN
    logic [15:0] checksum_r;

    // Running modulo-2^16 sum of accepted bytes.
    always_ff @(posedge wclk) begin
        if (reset || start_s) begin
            checksum_r <= 16'h0000;
        end else if (accept_s) begin
            checksum_r <= checksum_r + {8'h00, rom_do};
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = 16'h0000;
`endif

    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;
    assign mem_din   = mem_din_r;
    assign mem_ds    = mem_ds_r;
    assign load_done = load_done_r;
    assign byte_cnt  = byte_cnt_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_rom_sdram_writer.sv
// Directed bench for rom_sdram_writer: a default instance plus a depth-2
// instance for the overflow case, each with a small SDRAM acknowledge model.
module tb_rom_sdram_writer;

    logic        wclk = 1'b0;
    logic        reset;
    logic        rom_loading;
    logic        rom_loading2;
    logic [7:0]  rom_do;
    logic        rom_do_valid;
    logic [23:0] rom_mask;

    logic        mem_req, mem_req2;
    logic        mem_ack = 1'b0;
    logic        mem_ack2 = 1'b0;
    logic [22:0] mem_addr, mem_addr2;
    logic [15:0] mem_din, mem_din2;
    logic [1:0]  mem_ds, mem_ds2;
    logic        load_done, load_done2;
    logic [23:0] byte_cnt, byte_cnt2;
    logic        overflow, overflow2;
    logic [15:0] checksum, checksum2;

    int checks = 0;
    int errors = 0;

    logic        ack_en = 1'b1;
    logic        ack_en2 = 1'b1;
    logic        req_prev = 1'b0;
    logic        req_prev2 = 1'b0;
    int          wr_n = 0;
    int          wr2_n = 0;
    int          done_n = 0;
    int          done2_n = 0;
    logic [22:0] wa  [64];
    logic [15:0] wd  [64];
    logic [1:0]  wds [64];
    logic [22:0] wa2 [64];
    logic [15:0] wd2 [64];
    logic [7:0]  stim [16];
    logic        req_seen [16];

    always #5 wclk = ~wclk;

    rom_sdram_writer dut (
        .wclk (wclk), .reset (reset), .rom_loading (rom_loading),
        .rom_do (rom_do), .rom_do_valid (rom_do_valid), .rom_mask (rom_mask),
        .mem_req (mem_req), .mem_ack (mem_ack), .mem_addr (mem_addr),
        .mem_din (mem_din), .mem_ds (mem_ds), .load_done (load_done),
        .byte_cnt (byte_cnt), .overflow (overflow), .checksum (checksum)
    );

    rom_sdram_writer #(.FIFO_DEPTH (2)) dut2 (
        .wclk (wclk), .reset (reset), .rom_loading (rom_loading2),
        .rom_do (rom_do), .rom_do_valid (rom_do_valid), .rom_mask (rom_mask),
        .mem_req (mem_req2), .mem_ack (mem_ack2), .mem_addr (mem_addr2),
        .mem_din (mem_din2), .mem_ds (mem_ds2), .load_done (load_done2),
        .byte_cnt (byte_cnt2), .overflow (overflow2), .checksum (checksum2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SDRAM model for dut: acknowledge one cycle after the request rises, log the write.
    always @(negedge wclk) begin
        if (reset) begin
            mem_ack  = 1'b0;
            req_prev = 1'b0;
        end else if (mem_ack) begin
            mem_ack  = 1'b0;
            req_prev = 1'b0;
        end else begin
            if (ack_en && mem_req && req_prev) begin
                mem_ack = 1'b1;
                if (wr_n < 64) begin
                    wa[wr_n]  = mem_addr;
                    wd[wr_n]  = mem_din;
                    wds[wr_n] = mem_ds;
                end
                wr_n++;
            end
            req_prev = mem_req;
        end
        if (load_done) done_n++;
    end

    // SDRAM model for dut2.
    always @(negedge wclk) begin
        if (reset) begin
            mem_ack2  = 1'b0;
            req_prev2 = 1'b0;
        end else if (mem_ack2) begin
            mem_ack2  = 1'b0;
            req_prev2 = 1'b0;
        end else begin
            if (ack_en2 && mem_req2 && req_prev2) begin
                mem_ack2 = 1'b1;
                if (wr2_n < 64) begin
                    wa2[wr2_n] = mem_addr2;
                    wd2[wr2_n] = mem_din2;
                end
                wr2_n++;
            end
            req_prev2 = mem_req2;
        end
        if (load_done2) done2_n++;
    end

    task automatic start_load();
        @(negedge wclk);
        rom_loading = 1'b1;
        @(negedge wclk);
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) begin
            rom_do       = stim[i];
            rom_do_valid = 1'b1;
            @(negedge wclk);
            req_seen[i]  = mem_req;
        end
        rom_do_valid = 1'b0;
    endtask

    task automatic wait_done(input bit second, input int base, input string tag);
        int k;
        k = 0;
        while (((second ? done2_n : done_n) == base) && (k < 300)) begin
            @(negedge wclk);
            k++;
        end
        repeat (3) @(negedge wclk);
        check_eq(tag, (second ? done2_n : done_n) - base, 32'd1);
    endtask

    int bw, bd;
    logic [15:0] exp_sum1, exp_sum2;

    initial begin
`ifdef ROM_SDRAM_WRITER_CHECKSUM_EN
        exp_sum1 = 16'h000A;
        exp_sum2 = 16'h0231;
`else
        exp_sum1 = 16'h0000;
        exp_sum2 = 16'h0000;
`endif
        reset = 1'b1; rom_loading = 1'b0; rom_loading2 = 1'b0;
        rom_do = 8'h00; rom_do_valid = 1'b0; rom_mask = 24'hFFFFFF;
        repeat (3) @(negedge wclk);
        check_eq("rst_req", mem_req, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_din", mem_din, 32'd0);
        check_eq("rst_ds", mem_ds, 32'd0);
        check_eq("rst_done", load_done, 32'd0);
        check_eq("rst_cnt", byte_cnt, 32'd0);
        check_eq("rst_ovf", overflow, 32'd0);
        check_eq("rst_sum", checksum, 32'd0);
        reset = 1'b0;

        // Four bytes, two full words
        bw = wr_n; bd = done_n;
        stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim[3] = 8'h04;
        start_load();
        send_n(4);
        rom_loading = 1'b0;
        wait_done(1'b0, bd, "t1_done");
        check_eq("t1_lat_t1", req_seen[1], 32'd0);
        check_eq("t1_lat_t2", req_seen[2], 32'd1);
        check_eq("t1_nwr", wr_n - bw, 32'd2);
        check_eq("t1_a0", wa[bw], 32'h000000);
        check_eq("t1_d0", wd[bw], 32'h0201);
        check_eq("t1_s0", wds[bw], 32'd3);
        check_eq("t1_a1", wa[bw+1], 32'h000002);
        check_eq("t1_d1", wd[bw+1], 32'h0403);
        check_eq("t1_s1", wds[bw+1], 32'd3);
        check_eq("t1_cnt", byte_cnt, 32'd4);
        check_eq("t1_sum", checksum, {16'h0000, exp_sum1});
        check_eq("t1_ovf", overflow, 32'd0);

        // Odd length: trailing half word
        bw = wr_n; bd = done_n;
        stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
        start_load();
        send_n(3);
        rom_loading = 1'b0;
        wait_done(1'b0, bd, "t2_done");
        check_eq("t2_nwr", wr_n - bw, 32'd2);
        check_eq("t2_d0", wd[bw], 32'hBBAA);
        check_eq("t2_a1", wa[bw+1], 32'h000002);
        check_eq("t2_d1", wd[bw+1], 32'h00CC);
        check_eq("t2_s1", wds[bw+1], 32'd1);
        check_eq("t2_cnt", byte_cnt, 32'd3);
        check_eq("t2_sum", checksum, {16'h0000, exp_sum2});

        // Small mask: addresses mirror
        bw = wr_n; bd = done_n;
        rom_mask = 24'h000003;
        for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
        start_load();
        send_n(8);
        rom_loading = 1'b0;
        wait_done(1'b0, bd, "t3_done");
        check_eq("t3_nwr", wr_n - bw, 32'd4);
        check_eq("t3_a0", wa[bw], 32'h000000);
        check_eq("t3_a1", wa[bw+1], 32'h000002);
        check_eq("t3_a2", wa[bw+2], 32'h000000);
        check_eq("t3_a3", wa[bw+3], 32'h000002);
        check_eq("t3_d3", wd[bw+3], 32'h0807);
        check_eq("t3_ovf", overflow, 32'd0);
        rom_mask = 24'hFFFFFF;

        // rom_loading back high during FLUSH/DONE: second load follows
        bw = wr_n; bd = done_n;
        stim[0] = 8'h11; stim[1] = 8'h22;
        start_load();
        send_n(2);
        rom_loading = 1'b0;
        @(negedge wclk);
        rom_loading = 1'b1;
        wait_done(1'b0, bd, "t4_done_a");
        check_eq("t4_cnt_restart", byte_cnt, 32'd0);
        check_eq("t4_d0", wd[bw], 32'h2211);
        bw = wr_n; bd = done_n;
        stim[0] = 8'h33; stim[1] = 8'h44;
        send_n(2);
        rom_loading = 1'b0;
        wait_done(1'b0, bd, "t4_done_b");
        check_eq("t4_cnt2", byte_cnt, 32'd2);
        check_eq("t4_a0b", wa[bw], 32'h000000);
        check_eq("t4_d0b", wd[bw], 32'h4433);

        // Reset while a request is outstanding
        bd = done_n;
        ack_en = 1'b0;
        stim[0] = 8'h55; stim[1] = 8'h66;
        start_load();
        send_n(2);
        rom_loading = 1'b0;
        for (int k = 0; k < 20 && !mem_req; k++) @(negedge wclk);
        check_eq("t5_req_hi", mem_req, 32'd1);
        reset = 1'b1;
        @(negedge wclk);
        check_eq("t5_req_lo", mem_req, 32'd0);
        check_eq("t5_addr", mem_addr, 32'd0);
        check_eq("t5_din", mem_din, 32'd0);
        check_eq("t5_ds", mem_ds, 32'd0);
        check_eq("t5_cnt", byte_cnt, 32'd0);
        check_eq("t5_sum", checksum, 32'd0);
        reset = 1'b0;
        ack_en = 1'b1;
        repeat (6) @(negedge wclk);
        check_eq("t5_no_done", done_n - bd, 32'd0);
        check_eq("t5_idle_req", mem_req, 32'd0);

        // Depth-2 FIFO with a stalled write side
        bw = wr2_n; bd = done2_n;
        ack_en2 = 1'b0;
        for (int i = 0; i < 10; i++) stim[i] = 8'(i + 1);
        @(negedge wclk);
        rom_loading2 = 1'b1;
        @(negedge wclk);
        send_n(10);
        rom_loading2 = 1'b0;
        repeat (12) @(negedge wclk);
        check_eq("t6_stall_nwr", wr2_n - bw, 32'd0);
        ack_en2 = 1'b1;
        wait_done(1'b1, bd, "t6_done");
        check_eq("t6_ovf", overflow2, 32'd1);
        check_eq("t6_nwr", wr2_n - bw, 32'd3);
        check_eq("t6_d0", wd2[bw], 32'h0201);
        check_eq("t6_d2", wd2[bw+2], 32'h0605);
        check_eq("t6_a2", wa2[bw+2], 32'h000004);
        check_eq("t6_cnt", byte_cnt2, 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
